surf_cmd_deserializer: RTL and testbench
========================================

// Module: surf_cmd_deserializer
// PURPOSE
//  Decodes the serial trigger/command line (cmd_i, one bit per clk_i) into the parallel event-ID
//  write and per-buffer LAB digitize strobes. Output feeds the event-ID FIFO and LAB digitize
//  inputs of the LAB/HK local-bus readout block.
//  Adds odd-parity and framing checks plus a saturating error count readable through a status register.
// PARAMETERS
//  ID_BITS     32  event ID payload width
//  BUF_BITS    2   buffer-select width; NBUF = 2**BUF_BITS digitize lines
//  DIG_WIDTH   1   digitize_o pulse width in clk_i cycles (1..15)
// PORTS
//  clk_i              in   1         system clock (33 MHz); sole clock
//  rst_i              in   1         reset, synchronous, active-high
//  cmd_i              in   1         serial command line, idle low
//  event_id_wr_o      out  1         1-cycle strobe: event_id_o/event_id_buffer_o valid, push to FIFO
//  event_id_o         out  ID_BITS   last accepted TRIGGER event ID (held)
//  event_id_buffer_o  out  BUF_BITS  buffer of last accepted TRIGGER (held)
//  digitize_o         out  NBUF      one-hot digitize strobe, DIG_WIDTH cycles
//  cmd_err_o          out  1         1-cycle strobe on parity or framing error
//  err_count_o        out  8         saturating error count
//  err_clr_i          in   1         synchronous clear of err_count_o
// BEHAVIOUR
//  - Frame, MSB first, one bit per clock: START(1) TYPE[1:0] BUF[BUF_BITS-1:0] ID[ID_BITS-1:0]
//    PAR STOP(0). 39 bits at defaults.
//  - PAR: odd parity over TYPE, BUF, ID, PAR.
//  - cmd_i is registered once (IOB) before the FSM. All logic runs on posedge clk_i.
//  - FSM states: IDLE, HDR, ID, PAR, STOP.
//    IDLE -> HDR when registered cmd=1.
//    HDR counts 2+BUF_BITS bits, then ID; ID counts ID_BITS bits, then PAR; PAR 1 bit, then STOP;
//    STOP always -> IDLE.
//    A 6-bit bit counter is reloaded on each state entry.
//  - STOP evaluation:
//    - stop bit must be 0 and parity must be odd, else: cmd_err_o pulse, err_count_o+1
//      (saturates at 255), no other output.
//    - Valid TYPE=2'b01 (TRIGGER): event_id_wr_o=1 for 1 cycle; event_id_o and event_id_buffer_o
//      update in the same cycle; digitize_o[BUF] starts.
//    - Valid TYPE=2'b10 (DIGITIZE): digitize_o[BUF] only; event_id_* unchanged, no wr strobe.
//    - Valid TYPE=2'b00/2'b11: frame consumed silently, no outputs, no error.
//  - Latency: strobes assert in the clock cycle after the edge that sampled the registered stop
//    bit, i.e. 2 cycles after the stop bit is presented on cmd_i.
//  - Back-to-back: a START presented on cmd_i the cycle after STOP is accepted (no idle gap required).
//  - digitize_o: a new digitize arriving while a previous pulse is still active restarts the width
//    counter and ORs in the new bit; earlier bits drop when the counter expires.
//  - Reset values: event_id_wr_o=0, event_id_o=0, event_id_buffer_o=0, digitize_o=0, cmd_err_o=0,
//    err_count_o=0, FSM=IDLE.
//  - rst_i mid-frame: partial frame discarded, FSM=IDLE next cycle, no strobe.
//    Bits still arriving are parsed from IDLE; an errant '1' starts a frame that will likely fail
//    parity/stop and count as an error.
//  - err_clr_i and an error in the same cycle: clear wins, count=0.
// STRUCTURE
//  - surf_cmd_defs.vh: TYPE codes (CMD_TRIG=2'b01, CMD_DIG=2'b10), FSM state encodings,
//    header/frame bit counts.
//  - Sub-module surf_cmd_shift: (2+BUF_BITS+ID_BITS)-bit shift register with running parity XOR,
//    cleared on START. Outputs: type, buf, id fields, parity_ok.
//  - Top level holds the FSM, bit counter, digitize width counter and error counter.
// TESTING
//  1. TRIGGER, BUF=2, ID=0xDEADBEEF, correct parity:
//     event_id_wr_o one cycle 2 clk after stop; event_id_o=0xDEADBEEF; event_id_buffer_o=2;
//     digitize_o=4'b0100 for DIG_WIDTH cycles.
//  2. Same frame with PAR inverted:
//     cmd_err_o pulse; err_count_o=1; no wr, no digitize; event_id_o keeps its prior value.
//  3. DIGITIZE, BUF=1, then TRIGGER, BUF=3, back-to-back with zero gap:
//     digitize_o=4'b0010, then wr strobe with buf=3 and digitize_o=4'b1000.
//     Exactly one wr strobe total.
//  4. TYPE=2'b11 frame, then STOP=1 on a valid TRIGGER:
//     first frame produces nothing; second frame gives err pulse, count+1.
//  5. rst_i asserted at bit 20 of a TRIGGER frame, released, then a full valid frame:
//     no strobe from the aborted frame; second frame decodes normally.
//  6. 300 parity-error frames, then err_clr_i coincident with a 301st error:
//     count saturates at 255, then reads 0.

Source files
------------

// File: rtl/surf_cmd_deserializer_pkg.sv
// Shared definitions for the serial command deserializer: command type codes,
// FSM state encoding and the per-frame decode result.
package surf_cmd_deserializer_pkg;

    localparam int         TYPE_BITS = 2;
    localparam logic [1:0] CMD_TRIG  = 2'b01;
    localparam logic [1:0] CMD_DIG   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ID   = 3'd2,
        ST_PAR  = 3'd3,
        ST_STOP = 3'd4
    } state_e;

    // Outcome of evaluating a frame at its stop bit.
    typedef struct packed {
        logic trig;
        logic dig;
        logic err;
    } decode_t;

endpackage

// File: rtl/surf_cmd_deserializer_shift.sv
// Payload shift register {TYPE, BUF, ID} with running parity over payload and PAR bit.
module surf_cmd_shift #(
    parameter int ID_BITS  = 32,
    parameter int BUF_BITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                shift_i,
    input  logic                par_i,
    input  logic                bit_i,
    output logic [1:0]          type_o,
    output logic [BUF_BITS-1:0] bsel_o,
    output logic [ID_BITS-1:0]  id_o,
    output logic                parity_ok_o
);
    localparam int PAY = 2 + BUF_BITS + ID_BITS;

    logic [PAY-1:0] sr;
    logic           par_acc;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sr      <= '0;
            par_acc <= 1'b0;
        end else begin
            if (shift_i)
                sr <= {sr[PAY-2:0], bit_i};
            if (shift_i || par_i)
                par_acc <= par_acc ^ bit_i;
        end
    end

    assign type_o      = sr[PAY-1 -: 2];
    assign bsel_o      = sr[ID_BITS +: BUF_BITS];
    assign id_o        = sr[ID_BITS-1:0];
    assign parity_ok_o = par_acc;

endmodule

// File: rtl/surf_cmd_deserializer.sv
// Serial trigger/command line decoder: frame FSM, event-ID write strobe,
// stretched per-buffer digitize strobes and a saturating error counter.
module surf_cmd_deserializer
    import surf_cmd_deserializer_pkg::*;
#(
    parameter int ID_BITS   = 32,
    parameter int BUF_BITS  = 2,
    parameter int DIG_WIDTH = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_i,
    output logic                      event_id_wr_o,
    output logic [ID_BITS-1:0]        event_id_o,
    output logic [BUF_BITS-1:0]       event_id_buffer_o,
    output logic [2**BUF_BITS-1:0]    digitize_o,
    output logic                      cmd_err_o,
    output logic [7:0]                err_count_o,
    input  logic                      err_clr_i
);
    localparam int              NBUF     = 2**BUF_BITS;
    localparam int              HDR_BITS = TYPE_BITS + BUF_BITS;
    localparam logic [NBUF-1:0] ONE      = NBUF'(1);

    logic                cmd_r;
    state_e              state;
    logic [5:0]          bit_cnt;
    logic [3:0]          dig_cnt;
    logic [1:0]          f_type;
    logic [BUF_BITS-1:0] f_bsel;
    logic [ID_BITS-1:0]  f_id;
    logic                parity_ok;
    decode_t             dec;

    surf_cmd_shift #(
        .ID_BITS  (ID_BITS),
        .BUF_BITS (BUF_BITS)
    ) u_shift (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (state == ST_IDLE && cmd_r),
        .shift_i     (state == ST_HDR || state == ST_ID),
        .par_i       (state == ST_PAR),
        .bit_i       (cmd_r),
        .type_o      (f_type),
        .bsel_o      (f_bsel),
        .id_o        (f_id),
        .parity_ok_o (parity_ok)
    );

    // In STOP, cmd_r holds the stop bit.
    always_comb begin
        dec = '0;
        if (state == ST_STOP) begin
            if (cmd_r || !parity_ok)
                dec.err = 1'b1;
            else if (f_type == CMD_TRIG) begin
                dec.trig = 1'b1;
                dec.dig  = 1'b1;
            end else if (f_type == CMD_DIG)
                dec.dig = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_r             <= 1'b0;
            state             <= ST_IDLE;
            bit_cnt           <= '0;
            dig_cnt           <= '0;
            event_id_wr_o     <= 1'b0;
            event_id_o        <= '0;
            event_id_buffer_o <= '0;
            digitize_o        <= '0;
            cmd_err_o         <= 1'b0;
            err_count_o       <= '0;
        end else begin
            cmd_r <= cmd_i;

            case (state)
                ST_IDLE: if (cmd_r) begin
                    state   <= ST_HDR;
                    bit_cnt <= 6'(HDR_BITS - 1);
                end
                ST_HDR: if (bit_cnt == 6'd0) begin
                    state   <= ST_ID;
                    bit_cnt <= 6'(ID_BITS - 1);
                end else
                    bit_cnt <= bit_cnt - 6'd1;
                ST_ID: if (bit_cnt == 6'd0) begin
                    state   <= ST_PAR;
                    bit_cnt <= '0;
                end else
                    bit_cnt <= bit_cnt - 6'd1;
                ST_PAR: begin
                    state   <= ST_STOP;
                    bit_cnt <= '0;
                end
                ST_STOP: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
                default: state <= ST_IDLE;
            endcase

            event_id_wr_o <= dec.trig;
            cmd_err_o     <= dec.err;
            if (dec.trig) begin
                event_id_o        <= f_id;
                event_id_buffer_o <= f_bsel;
            end

            if (err_clr_i)
                err_count_o <= '0;
            else if (dec.err && err_count_o != 8'hFF)
                err_count_o <= err_count_o + 8'd1;

            // Bits whose pulse ends on this edge drop even when a new one arrives.
            if (dec.dig) begin
                digitize_o <= ((dig_cnt > 4'd1) ? digitize_o : '0) | (ONE << f_bsel);
                dig_cnt    <= DIG_WIDTH[3:0];
            end else if (dig_cnt != 4'd0) begin
                dig_cnt <= dig_cnt - 4'd1;
                if (dig_cnt == 4'd1)
                    digitize_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_surf_cmd_deserializer.sv
// Self-checking bench: directed frame table, multi-cycle sequences and random
// frames against a cycle-stamped event model of the command decoder.
module tb_surf_cmd_deserializer;
    localparam int DIG_W = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_i = 1'b0;
    logic        err_clr_i = 1'b0;
    logic        event_id_wr_o;
    logic [31:0] event_id_o;
    logic [1:0]  event_id_buffer_o;
    logic [3:0]  digitize_o;
    logic        cmd_err_o;
    logic [7:0]  err_count_o;

    surf_cmd_deserializer #(.ID_BITS(32), .BUF_BITS(2), .DIG_WIDTH(DIG_W)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .cmd_i             (cmd_i),
        .event_id_wr_o     (event_id_wr_o),
        .event_id_o        (event_id_o),
        .event_id_buffer_o (event_id_buffer_o),
        .digitize_o        (digitize_o),
        .cmd_err_o         (cmd_err_o),
        .err_count_o       (err_count_o),
        .err_clr_i         (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model events: kind 0 = frame evaluated, 1 = error clear, 2 = reset.
    typedef struct {
        int          t;
        int          kind;
        logic [1:0]  ty;
        logic [1:0]  bsel;
        logic [31:0] id;
        logic        par;
        logic        stop;
    } ev_t;
    ev_t evq[$];

    logic        sb_en = 1'b0;
    logic [31:0] m_id = '0;
    logic [1:0]  m_buf = '0;
    logic [3:0]  m_dig = '0;
    int          m_dig_end = 0;
    int          m_cnt = 0;
    logic        m_wr, m_err;

    int wr_tot = 0, err_tot = 0;
    int dig_cyc[4] = '{0, 0, 0, 0};

    always @(negedge clk_i) begin
        logic [3:0] exp_dig;
        logic       ok;
        wr_tot  <= wr_tot + int'(event_id_wr_o);
        err_tot <= err_tot + int'(cmd_err_o);
        for (int b = 0; b < 4; b++) dig_cyc[b] <= dig_cyc[b] + int'(digitize_o[b]);
        if (sb_en) begin
            m_wr  = 1'b0;
            m_err = 1'b0;
            if (cyc >= m_dig_end) m_dig = '0;
            for (int i = 0; i < evq.size(); ) begin
                if (evq[i].t == cyc) begin
                    if (evq[i].kind == 2) begin
                        m_id = '0; m_buf = '0; m_dig = '0; m_dig_end = 0; m_cnt = 0;
                        m_wr = 1'b0; m_err = 1'b0;
                    end else if (evq[i].kind == 1) begin
                        m_cnt = 0;
                    end else begin
                        ok = ($countones({evq[i].ty, evq[i].bsel, evq[i].id, evq[i].par}) % 2 == 1)
                             && (evq[i].stop == 1'b0);
                        if (!ok) begin
                            m_err = 1'b1;
                            if (m_cnt < 255) m_cnt++;
                        end else if (evq[i].ty == 2'b01 || evq[i].ty == 2'b10) begin
                            if (evq[i].ty == 2'b01) begin
                                m_wr  = 1'b1;
                                m_id  = evq[i].id;
                                m_buf = evq[i].bsel;
                            end
                            m_dig     = m_dig | (4'b0001 << evq[i].bsel);
                            m_dig_end = cyc + DIG_W;
                        end
                    end
                    evq.delete(i);
                end else
                    i++;
            end
            exp_dig = (cyc < m_dig_end) ? m_dig : 4'b0000;
            checks++;
            if (event_id_wr_o !== m_wr || event_id_o !== m_id || event_id_buffer_o !== m_buf ||
                digitize_o !== exp_dig || cmd_err_o !== m_err || err_count_o !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL cycle %0d outputs: got wr=%b id=%h buf=%0d dig=%b err=%b cnt=%0d, want wr=%b id=%h buf=%0d dig=%b err=%b cnt=%0d",
                         cyc, event_id_wr_o, event_id_o, event_id_buffer_o, digitize_o, cmd_err_o,
                         err_count_o, m_wr, m_id, m_buf, exp_dig, m_err, m_cnt);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] ty, input logic [1:0] bsel, input logic [31:0] id,
                        input logic pflip, input logic stop);
        logic [38:0] fr;
        logic        par;
        ev_t         e;
        par = ~(^{ty, bsel, id}) ^ pflip;
        fr  = {1'b1, ty, bsel, id, par, stop};
        for (int i = 38; i >= 0; i--) begin
            @(posedge clk_i); #1;
            cmd_i = fr[i];
        end
        e = '{t: cyc + 2, kind: 0, ty: ty, bsel: bsel, id: id, par: par, stop: stop};
        evq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
            cmd_i = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0]  ty;
        logic [1:0]  bsel;
        logic [31:0] id;
        logic        pflip;
        logic        stop;
        int          exp_wr;
        int          exp_err;
        logic [3:0]  exp_dig;
        logic [31:0] exp_id;
        logic [1:0]  exp_buf;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[8];
    int   s_wr, s_err;
    int   s_dig[4];

    task automatic snap();
        s_wr  = wr_tot;
        s_err = err_tot;
        for (int b = 0; b < 4; b++) s_dig[b] = dig_cyc[b];
    endtask

    initial begin
        ev_t e;
        vecs[0] = '{2'b01, 2'd2, 32'hDEADBEEF, 1'b0, 1'b0, 1, 0, 4'b0100, 32'hDEADBEEF, 2'd2, 0};
        vecs[1] = '{2'b01, 2'd2, 32'hDEADBEEF, 1'b1, 1'b0, 0, 1, 4'b0000, 32'hDEADBEEF, 2'd2, 1};
        vecs[2] = '{2'b11, 2'd1, 32'h00001234, 1'b0, 1'b0, 0, 0, 4'b0000, 32'hDEADBEEF, 2'd2, 1};
        vecs[3] = '{2'b01, 2'd0, 32'hCAFEF00D, 1'b0, 1'b1, 0, 1, 4'b0000, 32'hDEADBEEF, 2'd2, 2};
        vecs[4] = '{2'b10, 2'd3, 32'h0BADF00D, 1'b0, 1'b0, 0, 0, 4'b1000, 32'hDEADBEEF, 2'd2, 2};
        vecs[5] = '{2'b00, 2'd2, 32'h55AA55AA, 1'b0, 1'b0, 0, 0, 4'b0000, 32'hDEADBEEF, 2'd2, 2};
        vecs[6] = '{2'b01, 2'd1, 32'h00000000, 1'b0, 1'b0, 1, 0, 4'b0010, 32'h00000000, 2'd1, 2};
        vecs[7] = '{2'b01, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 0, 4'b1000, 32'hFFFFFFFF, 2'd3, 2};

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        sb_en = 1'b1;
        @(negedge clk_i); #1;
        chk("reset_outputs", {event_id_wr_o, event_id_o, event_id_buffer_o, digitize_o, cmd_err_o, err_count_o}, 0);

        foreach (vecs[k]) begin
            snap();
            send(vecs[k].ty, vecs[k].bsel, vecs[k].id, vecs[k].pflip, vecs[k].stop);
            idle(DIG_W + 6);
            chk($sformatf("vec%0d_wr", k), wr_tot - s_wr, vecs[k].exp_wr);
            chk($sformatf("vec%0d_err", k), err_tot - s_err, vecs[k].exp_err);
            for (int b = 0; b < 4; b++)
                chk($sformatf("vec%0d_dig%0d_cycles", k, b), dig_cyc[b] - s_dig[b],
                    vecs[k].exp_dig[b] ? DIG_W : 0);
            chk($sformatf("vec%0d_id", k), event_id_o, vecs[k].exp_id);
            chk($sformatf("vec%0d_buf", k), event_id_buffer_o, vecs[k].exp_buf);
            chk($sformatf("vec%0d_cnt", k), err_count_o, vecs[k].exp_cnt);
        end

        // Back-to-back DIGITIZE then TRIGGER with no idle gap.
        snap();
        send(2'b10, 2'd1, 32'h11111111, 1'b0, 1'b0);
        send(2'b01, 2'd3, 32'h13572468, 1'b0, 1'b0);
        idle(DIG_W + 6);
        chk("b2b_wr", wr_tot - s_wr, 1);
        chk("b2b_dig1", dig_cyc[1] - s_dig[1], DIG_W);
        chk("b2b_dig3", dig_cyc[3] - s_dig[3], DIG_W);
        chk("b2b_id", event_id_o, 32'h13572468);
        chk("b2b_buf", event_id_buffer_o, 3);

        // Reset during bit 20 of a TRIGGER frame, then a clean frame.
        snap();
        begin
            logic [38:0] fr;
            fr = {1'b1, 2'b01, 2'd2, 32'h89ABCDEF, ~(^{2'b01, 2'd2, 32'h89ABCDEF}), 1'b0};
            for (int i = 38; i >= 18; i--) begin
                @(posedge clk_i); #1;
                cmd_i = fr[i];
            end
            rst_i = 1'b1;
            e = '{t: cyc + 1, kind: 2, ty: 2'b00, bsel: 2'd0, id: 32'd0, par: 1'b0, stop: 1'b0};
            evq.push_back(e);
            @(posedge clk_i); #1;
            rst_i = 1'b0;
            cmd_i = 1'b0;
        end
        idle(45);
        chk("rst_abort_wr", wr_tot - s_wr, 0);
        chk("rst_abort_err", err_tot - s_err, 0);
        chk("rst_abort_id", event_id_o, 0);
        snap();
        send(2'b01, 2'd0, 32'hA5A50001, 1'b0, 1'b0);
        idle(DIG_W + 6);
        chk("post_rst_wr", wr_tot - s_wr, 1);
        chk("post_rst_id", event_id_o, 32'hA5A50001);

        // Random frames, checked cycle by cycle against the model.
        for (int n = 0; n < 80; n++) begin
            send(2'($urandom), 2'($urandom), $urandom, ($urandom_range(3) == 0),
                 ($urandom_range(5) == 0));
            idle($urandom_range(3));
        end
        idle(DIG_W + 6);

        // Saturation, then a clear coincident with an error.
        for (int n = 0; n < 300; n++)
            send(2'b01, 2'(n), 32'(n), 1'b1, 1'b0);
        idle(4);
        chk("err_saturated", err_count_o, 255);
        snap();
        send(2'b01, 2'd1, 32'h0, 1'b1, 1'b0);
        @(posedge clk_i); #1;
        cmd_i     = 1'b0;
        err_clr_i = 1'b1;
        e = '{t: cyc + 1, kind: 1, ty: 2'b00, bsel: 2'd0, id: 32'd0, par: 1'b0, stop: 1'b0};
        evq.push_back(e);
        @(posedge clk_i); #1;
        err_clr_i = 1'b0;
        idle(4);
        chk("clr_wins_cnt", err_count_o, 0);
        chk("clr_wins_err_pulse", err_tot - s_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
